// File: rtl/serdes_pkg.sv
// serdes_pkg: comma constants, aligner state encoding and small helpers shared
//   by the receive aligner, the link monitor and the encoder side.
// Latency: n/a (constants, types and pure functions only). Backpressure: n/a.
package serdes_pkg;

  // K28.5 in {j,h,g,f,i,e,d,c,b,a} order, i.e. bit0 = 'a' (first on the wire).
  localparam logic [9:0] K28_5_NEG = 10'h17C;
  localparam logic [9:0] K28_5_POS = 10'h283;

  // Aligner FSM encoding. Kept as plain constants so that older blocks
  // comparing raw state values keep working.
  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] ACQ    = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  // One framed 10-bit symbol together with its K28.5 flag.
  typedef struct packed {
    logic       is_k;
    logic [9:0] dat;
  } rx_word_t;

  // Bit position inside a 10-bit frame, wrapping 9 -> 0.
  function automatic logic [3:0] bit_cnt_inc(input logic [3:0] cnt);
    return (cnt == 4'd9) ? 4'd0 : cnt + 4'd1;
  endfunction

endpackage

// File: rtl/serdes_comma_detect.sv
// serdes_comma_detect: flags a K28.5 comma (either running disparity) in a 10-bit window.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the caller decides when the window is meaningful.
//
// Ports:
//   sr     in  10  candidate window, bit0 = 'a'
//   comma  out 1   window equals COMMA_NEG or COMMA_POS
module serdes_comma_detect
  import serdes_pkg::*;
#(
  parameter logic [9:0] COMMA_NEG = K28_5_NEG,
  parameter logic [9:0] COMMA_POS = K28_5_POS
) (
  input  logic [9:0] sr,
  output logic       comma
);

  assign comma = (sr == COMMA_NEG) || (sr == COMMA_POS);

endmodule

// File: rtl/serdes_rx_aligner.sv
// serdes_rx_aligner: 8b/10b receive word aligner; hunts K28.5 at any bit phase, locks framing, emits 10-bit words.
// Latency: word_out/word_valid are registered 1 clk after the sample edge of a word's last bit.
// Backpressure: none downstream; ser_en low freezes all shift/count/FSM state and suppresses strobes.
//
// Ports:
//   clk          in   1   single clock, rising edge
//   rst          in   1   synchronous reset, active-high
//   ser_in       in   1   serial data, bit 'a' first
//   ser_en       in   1   ser_in valid this cycle
//   word_out     out  10  aligned word, bit0 = 'a'; held between strobes
//   word_valid   out  1   1-cycle strobe, word_out updated
//   word_is_k    out  1   word_out is K28.5, qualified by word_valid
//   locked       out  1   FSM in LOCKED
//   realign      out  1   1-cycle pulse when bit phase is (re)established
//   realign_cnt  out  16  saturating count of realign pulses       (RX_ALIGN_STATS_EN only)
//   misalign_cnt out  16  saturating count of off-frame commas while locked (RX_ALIGN_STATS_EN only)
//
// Build option: define RX_ALIGN_STATS_EN to add the two statistics counters.
module serdes_rx_aligner
  import serdes_pkg::*;
#(
  parameter int         LOCK_COMMAS = 3,
  parameter int         LOSS_COMMAS = 2,
  parameter logic [9:0] COMMA_NEG   = K28_5_NEG,
  parameter logic [9:0] COMMA_POS   = K28_5_POS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ser_in,
  input  logic        ser_en,
  output logic [9:0]  word_out,
  output logic        word_valid,
  output logic        word_is_k,
  output logic        locked,
  output logic        realign
`ifdef RX_ALIGN_STATS_EN
  ,
  output logic [15:0] realign_cnt,
  output logic [15:0] misalign_cnt
`endif
);

  localparam int ACQ_W  = $clog2(LOCK_COMMAS + 1);
  localparam int MISS_W = $clog2(LOSS_COMMAS + 1);
  localparam logic [ACQ_W-1:0]  ACQ_MAX  = ACQ_W'(LOCK_COMMAS);
  localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(LOSS_COMMAS);

  logic [9:0]        sr;
  logic [3:0]        bit_cnt;
  logic              shifted;
  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [ACQ_W-1:0]  acq;
  logic [ACQ_W-1:0]  acq_nxt;
  logic [ACQ_W-1:0]  acq_inc;
  logic [MISS_W-1:0] miss;
  logic [MISS_W-1:0] miss_nxt;
  logic [MISS_W-1:0] miss_inc;
  logic              comma;
  logic              boundary;
  logic              emit;
  logic              reframe;
  rx_word_t          word_q;

  serdes_comma_detect #(
    .COMMA_NEG (COMMA_NEG),
    .COMMA_POS (COMMA_POS)
  ) u_comma_detect (
    .sr    (sr),
    .comma (comma)
  );

  // bit_cnt == 0 means sr holds exactly one frame's worth of new bits.
  assign boundary = (bit_cnt == 4'd0);
  assign acq_inc  = (acq  == ACQ_MAX)  ? acq  : acq  + 1'b1;
  assign miss_inc = (miss == MISS_MAX) ? miss : miss + 1'b1;

  // Decisions are taken only in the cycle after a shift, so a given sr
  // content is judged exactly once even when ser_en stalls.
  always_comb begin
    state_nxt = state;
    acq_nxt   = acq;
    miss_nxt  = miss;
    emit      = 1'b0;
    reframe   = 1'b0;
    if (shifted) begin
      case (state)
        HUNT: begin
          if (comma) begin
            reframe  = 1'b1;
            emit     = 1'b1;
            acq_nxt  = ACQ_W'(1);
            miss_nxt = '0;
            state_nxt = (ACQ_MAX == ACQ_W'(1)) ? LOCKED : ACQ;
          end
        end
        ACQ: begin
          if (comma && !boundary) begin
            // New phase wins: restart acquisition counting from this comma.
            reframe = 1'b1;
            emit    = 1'b1;
            acq_nxt = ACQ_W'(1);
            if (ACQ_MAX == ACQ_W'(1)) begin
              state_nxt = LOCKED;
            end
          end else if (boundary) begin
            emit = 1'b1;
            if (comma) begin
              acq_nxt = acq_inc;
              if (acq_inc == ACQ_MAX) begin
                state_nxt = LOCKED;
                miss_nxt  = '0;
              end
            end
          end
        end
        LOCKED: begin
          if (boundary) begin
            emit = 1'b1;
            if (comma) begin
              miss_nxt = '0;
            end
          end else if (comma) begin
            // Framing is frozen while locked; off-frame commas only count.
            if (miss_inc == MISS_MAX) begin
              state_nxt = HUNT;
              miss_nxt  = '0;
              acq_nxt   = '0;
            end else begin
              miss_nxt = miss_inc;
            end
          end
        end
        default: begin
          state_nxt = HUNT;
          acq_nxt   = '0;
          miss_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr         <= '0;
      bit_cnt    <= '0;
      shifted    <= 1'b0;
      state      <= HUNT;
      acq        <= '0;
      miss       <= '0;
      word_q     <= '0;
      word_valid <= 1'b0;
      realign    <= 1'b0;
    end else begin
      shifted    <= ser_en;
      state      <= state_nxt;
      acq        <= acq_nxt;
      miss       <= miss_nxt;
      word_valid <= emit;
      realign    <= reframe;
      if (ser_en) begin
        sr      <= {ser_in, sr[9:1]};
        bit_cnt <= bit_cnt_inc(bit_cnt);
      end
      // The comma in sr is frame position 0; the next enabled bit is position 1.
      if (reframe) begin
        bit_cnt <= ser_en ? 4'd1 : 4'd0;
      end
      if (emit) begin
        word_q.dat  <= sr;
        word_q.is_k <= comma;
      end
    end
  end

  assign word_out  = word_q.dat;
  assign word_is_k = word_q.is_k;
  assign locked    = (state == LOCKED);

`ifdef RX_ALIGN_STATS_EN
  logic misalign_evt;

  assign misalign_evt = shifted && (state == LOCKED) && comma && !boundary;

  always_ff @(posedge clk) begin
    if (rst) begin
      realign_cnt  <= '0;
      misalign_cnt <= '0;
    end else begin
      if (reframe && (realign_cnt != 16'hFFFF)) begin
        realign_cnt <= realign_cnt + 16'd1;
      end
      if (misalign_evt && (misalign_cnt != 16'hFFFF)) begin
        misalign_cnt <= misalign_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_serdes_rx_aligner.sv
// tb_serdes_rx_aligner: directed bench for the receive word aligner.
// Latency: n/a. Backpressure: exercised through ser_en stalls.
module tb_serdes_rx_aligner;
  import serdes_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       ser_in;
  logic       ser_en;
  logic [9:0] word_out;
  logic       word_valid;
  logic       word_is_k;
  logic       locked;
  logic       realign;
`ifdef RX_ALIGN_STATS_EN
  logic [15:0] realign_cnt;
  logic [15:0] misalign_cnt;
`endif

  always #5 clk = ~clk;

  serdes_rx_aligner dut (
    .clk        (clk),
    .rst        (rst),
    .ser_in     (ser_in),
    .ser_en     (ser_en),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_is_k  (word_is_k),
    .locked     (locked),
    .realign    (realign)
`ifdef RX_ALIGN_STATS_EN
    ,
    .realign_cnt  (realign_cnt),
    .misalign_cnt (misalign_cnt)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Strobe monitor: counts every word_valid / realign cycle and keeps the last emitted word.
  int         vld_cnt = 0;
  int         rlg_cnt = 0;
  int         cyc = 0;
  logic [9:0] last_word = '0;
  logic       last_k = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (word_valid) begin
      vld_cnt   <= vld_cnt + 1;
      last_word <= word_out;
      last_k    <= word_is_k;
    end
    if (realign) rlg_cnt <= rlg_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Shift one 10-bit word LSB first. tog=1 alternates ser_en 1/0 per bit.
  // Ends at the negedge where the strobe for this word's last bit is visible.
  task automatic send_word(input logic [9:0] w, input bit tog,
                           output int mid_vld, output int mid_rlg, output int t_end);
    int c0;
    int r0;
    c0 = 0;
    r0 = 0;
    for (int i = 0; i < 10; i++) begin
      ser_en = 1'b1;
      ser_in = w[i];
      @(negedge clk);
      if (i == 0) begin
        c0 = vld_cnt;
        r0 = rlg_cnt;
      end
      if (tog) begin
        ser_en = 1'b0;
        @(negedge clk);
      end
    end
    if (!tog) begin
      ser_en = 1'b0;
      @(negedge clk);
    end
    mid_vld = vld_cnt - c0;
    mid_rlg = rlg_cnt - r0;
    t_end   = cyc;
  endtask

  // Send a word and check the strobes at its end plus any strobes seen mid-word.
  // e_lock < 0 skips the locked check.
  task automatic word(input string tag, input logic [9:0] w, input bit tog,
                      input bit e_vld, input logic [9:0] e_out, input bit e_k,
                      input bit e_rlg, input int e_lock, input int e_mvld, input int e_mrlg,
                      output int t_end);
    int mv;
    int mr;
    send_word(w, tog, mv, mr, t_end);
    chk({tag, ".vld"}, 32'(word_valid), 32'(e_vld));
    if (e_vld) begin
      chk({tag, ".out"}, 32'(word_out), 32'(e_out));
      chk({tag, ".k"}, 32'(word_is_k), 32'(e_k));
    end
    chk({tag, ".rlg"}, 32'(realign), 32'(e_rlg));
    if (e_lock >= 0) chk({tag, ".lock"}, 32'(locked), e_lock);
    chk({tag, ".mid_vld"}, mv, e_mvld);
    chk({tag, ".mid_rlg"}, mr, e_mrlg);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    ser_en = 1'b0;
    ser_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  int t;
  int t_prev;

  initial begin
    // ---- 1: reset with live serial input ----
    rst    = 1'b1;
    ser_en = 1'b1;
    ser_in = 1'b0;
    repeat (2) begin
      ser_in = 1'($urandom);
      @(negedge clk);
    end
    chk("rst.out", 32'(word_out), 32'(0));
    chk("rst.vld", 32'(word_valid), 32'(0));
    chk("rst.k", 32'(word_is_k), 32'(0));
    chk("rst.lock", 32'(locked), 32'(0));
    chk("rst.rlg", 32'(realign), 32'(0));
    chk("rst.state", 32'(dut.state), 32'(HUNT));
`ifdef RX_ALIGN_STATS_EN
    chk("rst.rcnt", 32'(realign_cnt), 32'(0));
    chk("rst.mcnt", 32'(misalign_cnt), 32'(0));
`endif
    rst    = 1'b0;
    ser_en = 1'b1;

    // ---- 2: acquisition from an arbitrary phase ----
    ser_in = 1'b1; @(negedge clk);
    ser_in = 1'b0; @(negedge clk);
    ser_in = 1'b1; @(negedge clk);
    word("t2c1", 10'h17C, 0, 1, 10'h17C, 1, 1, 0, 0, 0, t);
    word("t2d1", 10'h0AA, 0, 1, 10'h0AA, 0, 0, 0, 0, 0, t);
    word("t2c2", 10'h283, 0, 1, 10'h283, 1, 0, 0, 0, 0, t);
    word("t2d2", 10'h0AA, 0, 1, 10'h0AA, 0, 0, 0, 0, 0, t);
    word("t2c3", 10'h17C, 0, 1, 10'h17C, 1, 0, -1, 0, 0, t);
    @(negedge clk);
    chk("t2.lock", 32'(locked), 32'(1));
    chk("t2.vld_off", 32'(word_valid), 32'(0));

    // ---- 3: K28.5 shifted 4 bits, twice -> loss of lock, then relock ----
    // 0x3CA,0x155 carry 17C across a frame boundary, completing at bit 3 of 0x155.
    word("t3d",  10'h0AA, 0, 1, 10'h0AA, 0, 0, 1, 0, 0, t);
    word("t3a1", 10'h3CA, 0, 1, 10'h3CA, 0, 0, 1, 0, 0, t);
    word("t3b1", 10'h155, 0, 1, 10'h155, 0, 0, 1, 0, 0, t);
    word("t3a2", 10'h3CA, 0, 1, 10'h3CA, 0, 0, 1, 0, 0, t);
    word("t3b2", 10'h155, 0, 0, 10'h000, 0, 0, 0, 0, 0, t);
`ifdef RX_ALIGN_STATS_EN
    chk("t3.mcnt", 32'(misalign_cnt), 32'(2));
`endif
    word("t3h",  10'h0AA, 0, 0, 10'h000, 0, 0, 0, 0, 0, t);
    word("t3r1", 10'h17C, 0, 1, 10'h17C, 1, 1, 0, 0, 0, t);
`ifdef RX_ALIGN_STATS_EN
    chk("t3.rcnt", 32'(realign_cnt), 32'(2));
    chk("t3.mcnt2", 32'(misalign_cnt), 32'(2));
`endif
    word("t3r2", 10'h17C, 0, 1, 10'h17C, 1, 0, 0, 0, 0, t);
    word("t3r3", 10'h17C, 0, 1, 10'h17C, 1, 0, -1, 0, 0, t);
    @(negedge clk);
    chk("t3.relock", 32'(locked), 32'(1));

    // ---- 6: reset mid-word discards the partial bits ----
    ser_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ser_in = (i >= 2);          // first five bits of 17C: 0,0,1,1,1
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    ser_en = 1'b0;
    chk("t6.vld", 32'(word_valid), 32'(0));
    chk("t6.lock", 32'(locked), 32'(0));
    chk("t6.rlg", 32'(realign), 32'(0));
    chk("t6.state", 32'(dut.state), 32'(HUNT));
`ifdef RX_ALIGN_STATS_EN
    chk("t6.rcnt", 32'(realign_cnt), 32'(0));
    chk("t6.mcnt", 32'(misalign_cnt), 32'(0));
`endif
    // Remaining five comma bits: would complete 17C only if the old bits survived.
    word("t6", 10'h00B, 0, 0, 10'h000, 0, 0, 0, 0, 0, t);

    // ---- 4: comma 5 bits off while acquiring ----
    // 0x395,0x2AB carry 17C with a 5-bit offset, completing at bit 4 of 0x2AB.
    word("t4c1", 10'h17C, 0, 1, 10'h17C, 1, 1, 0, 0, 0, t);
    word("t4d",  10'h0AA, 0, 1, 10'h0AA, 0, 0, 0, 0, 0, t);
    word("t4c2", 10'h17C, 0, 1, 10'h17C, 1, 0, 0, 0, 0, t);
    word("t4a",  10'h395, 0, 1, 10'h395, 0, 0, 0, 0, 0, t);
    word("t4b",  10'h2AB, 0, 0, 10'h000, 0, 0, 0, 1, 1, t);
    chk("t4b.mw", 32'(last_word), 32'(10'h17C));
    chk("t4b.mk", 32'(last_k), 32'(1));
`ifdef RX_ALIGN_STATS_EN
    chk("t4.rcnt", 32'(realign_cnt), 32'(2));
`endif
    // New frame straddles the test words: {0x2AB[9:5], 0x395[4:0]} = 0x2B5.
    word("t4a2", 10'h395, 0, 0, 10'h000, 0, 0, 0, 1, 0, t);
    chk("t4a2.mw", 32'(last_word), 32'(10'h2B5));
    word("t4b2", 10'h2AB, 0, 0, 10'h000, 0, 0, 0, 1, 0, t);
    chk("t4b2.mw", 32'(last_word), 32'(10'h17C));
    chk("t4b2.mk", 32'(last_k), 32'(1));
    word("t4a3", 10'h395, 0, 0, 10'h000, 0, 0, 0, 1, 0, t);
    word("t4b3", 10'h2AB, 0, 0, 10'h000, 0, 0, 1, 1, 0, t);

    // ---- 5: locked, ser_en toggling ----
    do_reset();
    word("t5c1", 10'h17C, 0, 1, 10'h17C, 1, 1, 0, 0, 0, t);
    word("t5c2", 10'h17C, 0, 1, 10'h17C, 1, 0, 0, 0, 0, t);
    word("t5c3", 10'h17C, 0, 1, 10'h17C, 1, 0, -1, 0, 0, t);
    word("t5d1", 10'h0AA, 1, 1, 10'h0AA, 0, 0, 1, 0, 0, t_prev);
    word("t5k",  10'h283, 1, 1, 10'h283, 1, 0, 1, 0, 0, t);
    chk("t5.per1", t - t_prev, 20);
    t_prev = t;
    word("t5d2", 10'h0AA, 1, 1, 10'h0AA, 0, 0, 1, 0, 0, t);
    chk("t5.per2", t - t_prev, 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
